// File: rtl/compositor_pkg.sv
// Shared constants for the sprite layer compositor.
package compositor_pkg;
    localparam int                 COLOR_W_DEF = 16;
    localparam int                 MAX_LATENCY = 4;
    localparam int                 COUNT_W     = 16;
    localparam logic [COUNT_W-1:0] COUNT_SAT   = '1;
endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with async clear; DEPTH=0 is a plain wire.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused;
            assign unused = ^{clk, rst};
            assign q_o    = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/layer_compositor.sv
// Sprite layer compositor: frame-synchronous layer mask, priority select,
// aligned sync/pixel delay line and per-frame collision statistics.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int N_LAYERS = 8,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int LATENCY  = 2,
    parameter int COL_A    = 3,
    parameter int COL_B    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic                         in_de,
    input  logic                         new_frame,
    input  logic [N_LAYERS-1:0]          layer_pe,
    input  logic [N_LAYERS*COLOR_W-1:0]  layer_color,
    input  logic [COLOR_W-1:0]           bg_color,
    input  logic [N_LAYERS-1:0]          mask_next,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic                         out_de,
    output logic [COLOR_W-1:0]           out_rgb,
    output logic                         collide_pulse,
    output logic                         collide_flag,
    output logic [COUNT_W-1:0]           collide_count
);
    localparam int LAT_C = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                           (LATENCY < 1) ? 1 : LATENCY;
    localparam int DLY_D = (LAT_C == 1) ? 1 : LAT_C - 1;

    logic [N_LAYERS-1:0] mask_q;
    logic [N_LAYERS-1:0] vis_in;
    logic                hit;

    assign vis_in = layer_pe & mask_q;
    assign hit    = in_de & vis_in[COL_A] & vis_in[COL_B];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            mask_q <= '0;
        else if (new_frame) mask_q <= mask_next;
    end

    // Select operands: raw inputs at LATENCY=1, first register otherwise
    logic [N_LAYERS-1:0]         vis_s;
    logic [N_LAYERS*COLOR_W-1:0] col_s;
    logic [COLOR_W-1:0]          bg_s;
    logic                        hs_s, vs_s, de_s;

    generate
        if (LAT_C == 1) begin : g_direct
            assign vis_s = vis_in;
            assign col_s = layer_color;
            assign bg_s  = bg_color;
            assign hs_s  = in_hsync;
            assign vs_s  = in_vsync;
            assign de_s  = in_de;
        end else begin : g_stage1
            logic [N_LAYERS-1:0]         vis_q;
            logic [N_LAYERS*COLOR_W-1:0] col_q;
            logic [COLOR_W-1:0]          bg_q;
            logic                        hs_q, vs_q, de_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vis_q <= '0;
                    col_q <= '0;
                    bg_q  <= '0;
                    hs_q  <= 1'b0;
                    vs_q  <= 1'b0;
                    de_q  <= 1'b0;
                end else begin
                    vis_q <= vis_in;
                    col_q <= layer_color;
                    bg_q  <= bg_color;
                    hs_q  <= in_hsync;
                    vs_q  <= in_vsync;
                    de_q  <= in_de;
                end
            end
            assign vis_s = vis_q;
            assign col_s = col_q;
            assign bg_s  = bg_q;
            assign hs_s  = hs_q;
            assign vs_s  = vs_q;
            assign de_s  = de_q;
        end
    endgenerate

    logic [COLOR_W-1:0] rgb_s;

    // Walk from the bottom layer up so the lowest visible index wins
    always_comb begin
        rgb_s = bg_s;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (vis_s[i]) rgb_s = col_s[i*COLOR_W +: COLOR_W];
        end
        if (!de_s) rgb_s = '0;
    end

    pipe_delay #(
        .WIDTH (COLOR_W + 3),
        .DEPTH (DLY_D)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({hs_s, vs_s, de_s, rgb_s}),
        .q_o ({out_hsync, out_vsync, out_de, out_rgb})
    );

    logic [COUNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
    logic               any_q, any_d, fired_q, fired_d;
    logic               pulse_q, pulse_d, flag_q, flag_d;

    // Frame boundary first, so a hit on the new_frame cycle opens the new frame
    always_comb begin
        acc_d   = acc_q;
        any_d   = any_q;
        fired_d = fired_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        pulse_d = 1'b0;
        if (new_frame) begin
            cnt_d   = acc_q;
            flag_d  = any_q;
            acc_d   = '0;
            any_d   = 1'b0;
            fired_d = 1'b0;
        end
        if (hit) begin
            if (acc_d != COUNT_SAT) acc_d = acc_d + COUNT_W'(1);
            any_d   = 1'b1;
            pulse_d = !fired_d;
            fired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
            fired_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            any_q   <= any_d;
            fired_q <= fired_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign collide_pulse = pulse_q;
    assign collide_flag  = flag_q;
    assign collide_count = cnt_q;
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 8, meaning number of sprite layers composited over background (legal 2..16).
REQ-002 Parameter COLOR_W, default 16, meaning pixel colour width (RGB565 at 16).
REQ-003 Parameter LATENCY, default 2, meaning input-to-output delay in clk cycles (legal 1..4).
REQ-004 Parameter COL_A, default 3, meaning first layer index monitored for collision.
REQ-005 Parameter COL_B, default 4, meaning second layer index monitored for collision (COL_B != COL_A).
REQ-006 clk  input  1  pixel clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_hsync  input  1  raw horizontal sync from scanner.
REQ-009 in_vsync  input  1  raw vertical sync from scanner.
REQ-010 in_de  input  1  raw data enable from scanner.
REQ-011 new_frame  input  1  one-cycle frame-start strobe from scanner.
REQ-012 layer_pe  input  N_LAYERS  per-layer paint enable; bit i belongs to layer i.
REQ-013 layer_color  input  N_LAYERS*COLOR_W  per-layer colour; layer i in bits [i*COLOR_W +: COLOR_W].
REQ-014 bg_color  input  COLOR_W  background colour.
REQ-015 mask_next  input  N_LAYERS  requested layer enables from game logic.
REQ-016 out_hsync, out_vsync, out_de  output  1 each  delayed syncs.
REQ-017 out_rgb  output  COLOR_W  composited pixel.
REQ-018 collide_pulse  output  1  first collision pixel of current frame.
REQ-019 collide_flag  output  1  previous frame contained at least one collision pixel.
REQ-020 collide_count  output  16  previous frame's collision pixel count.

Function
REQ-021 Active mask register shall load mask_next on every clk edge where new_frame=1; it is effective from the following cycle, so the mask is frame-synchronous and never changes mid-frame.
REQ-022 Layer i is visible at a pixel iff layer_pe[i] and mask[i].
REQ-023 Priority: lowest-index visible layer wins (layer 0 on top); if none visible, bg_color.
REQ-024 out_rgb shall be the winner colour when in_de=1, else all-zero.
REQ-025 out_hsync/out_vsync/out_de/out_rgb shall appear exactly LATENCY cycles after their inputs, with all four aligned in the same cycle.
REQ-026 LATENCY=1: priority select feeds a single output register; LATENCY>1: select after first register, remaining LATENCY-1 stages pure delay.
REQ-027 Collision pixel: in_de=1 and layers COL_A and COL_B both visible in the same cycle.
REQ-028 Frame accumulator: a running count (16-bit, saturating at 65535, no wrap) plus an any-hit bit.
REQ-029 On a new_frame cycle: collide_count and collide_flag shall load the accumulator values, and the accumulator shall restart so that a collision in that same cycle counts 1 toward the new frame.
REQ-030 collide_pulse shall be high for exactly one cycle, the cycle after the first collision pixel of a frame; it shall not re-fire until after the next new_frame.
REQ-031 new_frame with no collisions in the elapsed frame shall give collide_flag=0, collide_count=0.

Reset
REQ-032 While rst=1: all pipeline stages, outputs, mask, accumulator, collide_flag, collide_count and collide_pulse shall be 0; the mask cleared means only background is shown.
REQ-033 Reset asserted mid-frame shall discard the partial frame; the first new_frame after release shall report the counts accumulated since release.

Structure
REQ-034 Shared package compositor_pkg shall hold COLOR_W default, MAX_LATENCY=4, COUNT_W=16 and the saturation constant.
REQ-035 One sub-module pipe_delay (parameters WIDTH, DEPTH, DEPTH=0 is a wire) shall implement the sync/colour delay line.

Verification
REQ-036 rst=1 for 3 cycles with random inputs -> all outputs 0; after release with mask=0, out_rgb=bg_color when de=1.
REQ-037 mask=8'hFF, layer_pe=8'b0001_0100, colours layer2=16'hF800, layer4=16'h07E0 -> out_rgb=16'hF800 exactly LATENCY cycles later; the same timing holds for LATENCY=1 and 4.
REQ-038 mask_next changed mid-frame from 8'hFF to 8'h00 -> output unchanged until the cycle after next new_frame, then bg_color.
REQ-039 Layers 3 and 4 overlap for 37 de-pixels in one frame -> one collide_pulse, and at the next new_frame collide_flag=1, collide_count=37; the following empty frame gives 0/0.
REQ-040 70000 collision pixels in one frame -> collide_count=65535, with no wrap.
REQ-041 Collision on the new_frame cycle -> that pixel is excluded from the reported count and counts 1 in the next frame; in_de=0 with overlap -> no count and out_rgb=0.
